uart_tx_fifo: RTL



---
 rtl/uart_tx_fifo.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: parametrised UART transmitter with an input FIFO.
// Frames go out back-to-back while the FIFO holds data.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 50,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          i_data,
  input  logic                          i_valid,
  output logic                          o_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic                          o_tx,
  output logic                          o_active,
  output logic                          o_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
  localparam logic [AW:0]   FULL     = (AW + 1)'(FIFO_DEPTH);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_fifo: CLKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
    $error("uart_tx_fifo: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_par
    $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_sb
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fd
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2, >= 2");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          count;
  logic                 in_reset;
  logic                 push;
  logic                 pop;
  logic [DATA_BITS-1:0] head;
  logic                 par_head;

  state_t               state;
  state_t               state_n;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_n;
  logic [IW-1:0]        idx;
  logic [IW-1:0]        idx_n;
  logic                 stop_idx;
  logic                 stop_idx_n;
  logic                 tick;
  logic                 stop_last;
  logic [DATA_BITS-1:0] word_q;
  logic                 par_q;
  logic                 tx_n;
  logic                 active_n;
  logic                 done_n;

  // o_ready stays low through reset and rises on the first edge after it.
  assign o_ready      = !rst && !in_reset && (count != FULL);
  assign push         = i_valid && o_ready;
  assign o_fifo_count = count;
  assign head         = mem[rd_ptr];
  assign par_head     = (PARITY == 1) ? ~^head : ^head;
  assign tick         = (cnt == CNT_LAST);
  assign stop_last    = (STOP_BITS == 1) || stop_idx;

  // Remember whether the last edge was a reset edge.
  always_ff @(posedge clk) begin
    in_reset <= rst;
  end

  // FIFO storage; only written on an accepted word.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= i_data;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Latch the popped word and its parity for the frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
      par_q  <= 1'b0;
    end else if (pop) begin
      word_q <= head;
      par_q  <= par_head;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Bit timing counters and registered line outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      idx      <= '0;
      stop_idx <= 1'b0;
      o_tx     <= 1'b1;
      o_active <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      cnt      <= cnt_n;
      idx      <= idx_n;
      stop_idx <= stop_idx_n;
      o_tx     <= tx_n;
      o_active <= active_n;
      o_done   <= done_n;
    end
  end

  // Next state, next line value and FIFO pop decision.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    idx_n      = idx;
    stop_idx_n = stop_idx;
    tx_n       = o_tx;
    active_n   = o_active;
    done_n     = 1'b0;
    pop        = 1'b0;
    if (state != ST_IDLE) begin
      cnt_n = tick ? '0 : cnt + 1'b1;
    end
    unique case (state)
      ST_IDLE: begin
        cnt_n    = '0;
        tx_n     = 1'b1;
        active_n = 1'b0;
        if (count != '0) begin
          pop      = 1'b1;
          state_n  = ST_START;
          tx_n     = 1'b0;
          active_n = 1'b1;
        end
      end
      ST_START: begin
        if (tick) begin
          state_n = ST_DATA;
          idx_n   = '0;
          tx_n    = word_q[0];
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (idx == IDX_LAST) begin
            if (PARITY != 0) begin
              state_n = ST_PARITY;
              tx_n    = par_q;
            end else begin
              state_n    = ST_STOP;
              stop_idx_n = 1'b0;
              tx_n       = 1'b1;
            end
          end else begin
            idx_n = idx + 1'b1;
            tx_n  = word_q[idx_n];
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_n    = ST_STOP;
          stop_idx_n = 1'b0;
          tx_n       = 1'b1;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (stop_last) begin
            done_n = 1'b1;
            if (count != '0) begin
              pop     = 1'b1;
              state_n = ST_START;
              tx_n    = 1'b0;
            end else begin
              state_n  = ST_IDLE;
              tx_n     = 1'b1;
              active_n = 1'b0;
            end
          end else begin
            stop_idx_n = 1'b1;
          end
        end
      end
      default: begin
        state_n  = ST_IDLE;
        tx_n     = 1'b1;
        active_n = 1'b0;
      end
    endcase
  end

endmodule
